// File: rtl/mem_bist_pkg.sv
// Shared widths, FSM state encoding and the expected-pattern function for the memory BIST.
package mem_bist_pkg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 32;
   localparam int unsigned ERR_W  = 7;
   localparam int unsigned WAIT_W = 2;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      WAIT,
      DONE
   } bist_state_t;

   // Pattern for one address; inv selects the complemented polarity.
   function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] seed,
                                                  input logic              inv);
      return DATA_W'(addr) ^ seed ^ {DATA_W{inv}};
   endfunction

endpackage

// File: rtl/mem_bist_addr_cnt.sv
// Address counter with last-address flag, plus the read-latency wait down-counter.
module mem_bist_addr_cnt
   import mem_bist_pkg::*;
#(
   parameter int unsigned READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              inc_i,
   input  logic              wload_i,
   input  logic              wdec_i,
   output logic [ADDR_W-1:0] cnt_o,
   output logic              last_c,
   output logic              wzero_c
);

   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [WAIT_W-1:0] wcnt_q, wcnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      wcnt_d = wcnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + ADDR_W'(1);
      end
      if (wload_i) begin
         wcnt_d = WAIT_W'(READ_LAT - 1);
      end else if (wdec_i && (wcnt_q != '0)) begin
         wcnt_d = wcnt_q - WAIT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         wcnt_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         wcnt_q <= wcnt_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign last_c  = (cnt_q == ADDR_W'(DEPTH - 1));
   assign wzero_c = (wcnt_q == '0);

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST master for the 32x8 memory: write pattern, read back, compare, report.
// Define MEM_BIST_INV_PASS_EN to add a second write/read pass with the complemented pattern.
module mem_bist_ctrl
   import mem_bist_pkg::*;
#(
   parameter logic [DATA_W-1:0] SEED     = 8'hA5,
   parameter int unsigned       READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data_in,
   output logic              read,
   output logic              write,
   input  logic [DATA_W-1:0] data_out
);

   bist_state_t       state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_W-1:0] fail_data_q, fail_data_d;
   logic [DATA_W-1:0] data_in_q, data_in_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic              mism;
   logic              inv_cur;

   logic              cnt_clr, cnt_inc, w_load, w_dec;
   logic [ADDR_W-1:0] cnt;
   logic              cnt_last, w_zero;

`ifdef MEM_BIST_INV_PASS_EN
   logic inv_q, inv_d;
   assign inv_cur = inv_q;
`else
   assign inv_cur = 1'b0;
`endif

   mem_bist_addr_cnt #(
      .READ_LAT (READ_LAT)
   ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (cnt_clr),
      .inc_i   (cnt_inc),
      .wload_i (w_load),
      .wdec_i  (w_dec),
      .cnt_o   (cnt),
      .last_c  (cnt_last),
      .wzero_c (w_zero)
   );

   // Next state plus next value of every registered output.
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      err_d       = err_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      data_in_d   = data_in_q;
      read_d      = 1'b0;
      write_d     = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      mism        = 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
      inv_d       = inv_q;
`endif

      case (state_q)
         // DONE also accepts start so a held request is never lost.
         IDLE, DONE: begin
            if (state_q == DONE) begin
               state_d = IDLE;
            end
            if (start) begin
               state_d     = WRITE;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               err_d       = '0;
               fail_addr_d = '0;
               fail_data_d = '0;
               cnt_clr     = 1'b1;
               write_d     = 1'b1;
               data_in_d   = exp_data('0, SEED, 1'b0);
`ifdef MEM_BIST_INV_PASS_EN
               inv_d       = 1'b0;
`endif
            end
         end
         WRITE: begin
            if (cnt_last) begin
               state_d = READ;
               cnt_clr = 1'b1;
               read_d  = 1'b1;
            end else begin
               cnt_inc   = 1'b1;
               write_d   = 1'b1;
               data_in_d = exp_data(cnt + ADDR_W'(1), SEED, inv_cur);
            end
         end
         READ: begin
            state_d = WAIT;
            w_load  = 1'b1;
         end
         WAIT: begin
            if (w_zero) begin
               mism = (data_out != exp_data(cnt, SEED, inv_cur));
               if (mism) begin
                  err_d = err_q + ERR_W'(1);
                  if (err_q == '0) begin
                     fail_addr_d = cnt;
                     fail_data_d = data_out;
                  end
               end
               if (!cnt_last) begin
                  state_d = READ;
                  cnt_inc = 1'b1;
                  read_d  = 1'b1;
               end
`ifdef MEM_BIST_INV_PASS_EN
               else if (!inv_q) begin
                  state_d   = WRITE;
                  cnt_clr   = 1'b1;
                  inv_d     = 1'b1;
                  write_d   = 1'b1;
                  data_in_d = exp_data('0, SEED, 1'b1);
               end
`endif
               else begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == '0);
               end
            end else begin
               w_dec = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         data_in_q   <= '0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
         inv_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_q       <= err_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
         data_in_q   <= data_in_d;
         read_q      <= read_d;
         write_q     <= write_d;
`ifdef MEM_BIST_INV_PASS_EN
         inv_q       <= inv_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_addr = fail_addr_q;
   assign fail_data = fail_data_q;
   assign addr      = cnt;
   assign data_in   = data_in_q;
   assign read      = read_q;
   assign write     = write_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl: READ_LAT=1 and READ_LAT=3 instances, each with a 32x8 memory model.
module tb_mem_bist_ctrl;
   import mem_bist_pkg::*;

   localparam logic [7:0] SEED = 8'hA5;
`ifdef MEM_BIST_INV_PASS_EN
   localparam int NPASS = 2;
`else
   localparam int NPASS = 1;
`endif
   localparam int T1 = NPASS * (32 + 32 * 2);
   localparam int T3 = NPASS * (32 + 32 * 4);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // READ_LAT=1 instance
   logic       rst_n, start, busy, done, pass, read, write;
   logic [6:0] err_count;
   logic [4:0] fail_addr, addr;
   logic [7:0] fail_data, data_in, data_out;

   // READ_LAT=3 instance
   logic       rst3_n, start3, busy3, done3, pass3, read3, write3;
   logic [6:0] err_count3;
   logic [4:0] fail_addr3, addr3;
   logic [7:0] fail_data3, data_in3, data_out3;

   mem_bist_ctrl #(.SEED(SEED), .READ_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
      .addr(addr), .data_in(data_in), .read(read), .write(write), .data_out(data_out)
   );

   mem_bist_ctrl #(.SEED(SEED), .READ_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst3_n), .start(start3), .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err_count3), .fail_addr(fail_addr3), .fail_data(fail_data3),
      .addr(addr3), .data_in(data_in3), .read(read3), .write(write3), .data_out(data_out3)
   );

   logic [7:0] mem1 [32];
   logic [7:0] mem3 [32];
   int         fault_mode;
   logic [7:0] cap20;

   // Faults act on the read path. Bit0 of addr 20's pattern (8'hB1) is already 1,
   // so that cell is stuck-at-0 to make its fault observable.
   function automatic logic [7:0] faulty(input logic [4:0] a, input logic [7:0] d, input int mode);
      logic [7:0] r;
      r = d;
      if (mode == 1 && a == 5'd7)  r[0] = 1'b1;
      if (mode == 1 && a == 5'd20) r[0] = 1'b0;
      if (mode == 2 && a == 5'd3)  r[7] = 1'b0;
      return r;
   endfunction

   always @(posedge clk) begin
      if (write) mem1[addr] <= data_in;
      if (read) begin
         data_out <= faulty(addr, mem1[addr], fault_mode);
         if (addr == 5'd20) cap20 <= faulty(addr, mem1[addr], fault_mode);
      end
      if (write3) mem3[addr3] <= data_in3;
      if (read3) data_out3 <= mem3[addr3];
   end

   int rw_viol = 0;
   always @(negedge clk) begin
      if ((read && write) || (read3 && write3)) rw_viol++;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] outs1();
      return 64'({busy, done, pass, err_count, fail_addr, fail_data, addr, data_in, read, write});
   endfunction

   function automatic logic [63:0] outs3();
      return 64'({busy3, done3, pass3, err_count3, fail_addr3, fail_data3, addr3, data_in3, read3, write3});
   endfunction

   // Returns at the negedge after the edge that accepted start.
   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int cyc0, input bit repulse,
                            output int cyc, output int bcyc, output int nread);
      cyc   = cyc0;
      bcyc  = cyc0;
      nread = 0;
      while (!done && cyc < 1000) begin
         if (busy) bcyc++;
         if (read) nread++;
         if (repulse) start = (cyc == 5 || cyc == 50);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cyc, bcyc, nr, n, wr_bad, quiet;
      int         width_bad, gap_bad, last_rd, nrd;
      logic       prev_rd;
      logic [7:0] d0, d31;

      rst_n = 1'b0; rst3_n = 1'b0; start = 1'b0; start3 = 1'b0; fault_mode = 0;
      repeat (3) @(negedge clk);
      check("rst_outs", outs1(), 64'd0);
      check("rst_outs3", outs3(), 64'd0);
      rst_n = 1'b1; rst3_n = 1'b1;
      repeat (2) @(negedge clk);

      // Good memory, write sequence then full run
      do_start();
      wr_bad = 0; d0 = '0; d31 = '0;
      for (int i = 0; i < 32; i++) begin
         if (!(busy && write && !read && addr == 5'(i) && data_in == (8'(i) ^ SEED))) wr_bad++;
         if (i == 0)  d0  = data_in;
         if (i == 31) d31 = data_in;
         @(negedge clk);
      end
      check("t1_wr_seq_bad", 64'(wr_bad), 64'd0);
      check("t1_wr_a0", 64'(d0), 64'hA5);
      check("t1_wr_a31", 64'(d31), 64'hBA);
      wait_done(32, 1'b0, cyc, bcyc, nr);
      check("t1_done_cyc", 64'(cyc), 64'(T1));
      check("t1_busy_cyc", 64'(bcyc), 64'(T1));
      check("t1_busy_low", 64'(busy), 64'd0);
      check("t1_pass", 64'(pass), 64'd1);
      check("t1_err", 64'(err_count), 64'd0);
      check("t1_reads", 64'(nr), 64'(NPASS * 32));

      // Stuck bits at addr 7 and 20
      fault_mode = 1;
      do_start();
      wait_done(0, 1'b0, cyc, bcyc, nr);
      check("t2_done_cyc", 64'(cyc), 64'(T1));
      check("t2_pass", 64'(pass), 64'd0);
      check("t2_err", 64'(err_count), 64'd2);
      check("t2_fail_addr", 64'(fail_addr), 64'd7);
      check("t2_fail_data", 64'(fail_data), 64'hA3);
      check("t2_a20_differs", 64'(cap20 != 8'hB1), 64'd1);
      check("t2_a20_byte", 64'(cap20), 64'hB0);

      // Reset while waiting on addr 10
      fault_mode = 0;
      do_start();
      n = 0;
      while (!(read && addr == 5'd10) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("t3_found_rd10", 64'(read && addr == 5'd10), 64'd1);
      @(negedge clk);
      check("t3_in_wait", 64'({read, addr}), 64'({1'b0, 5'd10}));
      rst_n = 1'b0;
      @(negedge clk);
      check("t3_rst_outs", outs1(), 64'd0);
      rst_n = 1'b1;
      quiet = 0;
      repeat (4) begin
         @(negedge clk);
         if (read || write || busy) quiet++;
      end
      check("t3_no_strobes", 64'(quiet), 64'd0);
      do_start();
      wait_done(0, 1'b0, cyc, bcyc, nr);
      check("t3_done_cyc", 64'(cyc), 64'(T1));
      check("t3_pass", 64'(pass), 64'd1);

      // start re-pulsed mid-test, then held at completion
      do_start();
      wait_done(0, 1'b1, cyc, bcyc, nr);
      check("t4_done_cyc", 64'(cyc), 64'(T1));
      check("t4_pass", 64'(pass), 64'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t4_restart", 64'({busy, done}), 64'({1'b1, 1'b0}));
      wait_done(0, 1'b0, cyc, bcyc, nr);
      check("t4_rerun_cyc", 64'(cyc), 64'(T1));
      check("t4_rerun_pass", 64'(pass), 64'd1);

      // READ_LAT=3 instance: timing and read strobe spacing
      @(negedge clk);
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      cyc = 0; bcyc = 0; width_bad = 0; gap_bad = 0; last_rd = -1; nrd = 0; prev_rd = 1'b0;
      while (!done3 && cyc < 2000) begin
         if (busy3) bcyc++;
         if (write3) last_rd = -1;
         if (read3) begin
            nrd++;
            if (prev_rd) width_bad++;
            if (last_rd >= 0 && (cyc - last_rd) != 4) gap_bad++;
            last_rd = cyc;
         end
         prev_rd = read3;
         @(negedge clk);
         cyc++;
      end
      check("t5_done_cyc", 64'(cyc), 64'(T3));
      check("t5_busy_cyc", 64'(bcyc), 64'(T3));
      check("t5_pass", 64'(pass3), 64'd1);
      check("t5_err", 64'(err_count3), 64'd0);
      check("t5_reads", 64'(nrd), 64'(NPASS * 32));
      check("t5_rd_width_bad", 64'(width_bad), 64'd0);
      check("t5_rd_gap_bad", 64'(gap_bad), 64'd0);

      // addr 3 bit7 stuck-at-0: only the true-polarity pattern 8'hA6 sees it
      fault_mode = 2;
      do_start();
      wait_done(0, 1'b0, cyc, bcyc, nr);
      check("t6_done_cyc", 64'(cyc), 64'(T1));
      check("t6_pass", 64'(pass), 64'd0);
      check("t6_err", 64'(err_count), 64'd1);
      check("t6_fail_addr", 64'(fail_addr), 64'd3);
      check("t6_fail_data", 64'(fail_data), 64'h26);

      check("rw_exclusive", 64'(rw_viol), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
